// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: OFF/ON/BLINK/PWM/BREATHE/BURST per channel,
// sharing one tick prescaler and one free-running PWM counter.
module led_pattern_gen #(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned BURST_UNIT = 50,
  parameter int unsigned BURST_GAP  = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [3:0]          wr_ch,
  input  logic [2:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_arg,
  output logic [N_CH-1:0]     led,
  output logic                tick
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned PS_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PH_MAX0 = (256 > 2**PWM_BITS) ? 256 : 2**PWM_BITS;
  localparam int unsigned PH_MAX1 = (PH_MAX0 > BURST_UNIT) ? PH_MAX0 : BURST_UNIT;
  localparam int unsigned PH_MAX  = (PH_MAX1 > BURST_GAP) ? PH_MAX1 : BURST_GAP;
  localparam int unsigned PH_W    = $clog2(PH_MAX + 1);

  localparam logic [2:0] M_ON      = 3'd1;
  localparam logic [2:0] M_BLINK   = 3'd2;
  localparam logic [2:0] M_PWM     = 3'd3;
  localparam logic [2:0] M_BREATHE = 3'd4;
  localparam logic [2:0] M_BURST   = 3'd5;

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  typedef enum logic [1:0] {PULSE_HI, PULSE_LO, GAP} bst_t;

  logic [PS_W-1:0]     presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick_c;

  assign tick_c = (presc == PS_W'(DIV - 1));

  // Shared tick prescaler and PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      tick    <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      presc   <= tick_c ? '0 : presc + 1'b1;
      tick    <= tick_c;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [2:0]          mode;
    logic [PWM_BITS-1:0] arg;
    logic [PWM_BITS-1:0] duty;
    logic [PH_W-1:0]     phase;
    logic [3:0]          pulse;
    logic [3:0]          n_c;
    logic                dir_dn;
    logic                blink_lvl;
    logic                armed;
    logic                led_q;
    logic                led_c;
    logic                sel;
    logic                step_c;
    logic                unit_end_c;
    bst_t                bst;

    assign sel        = wr_en && (wr_ch == 4'(i));
    assign step_c     = (phase == PH_W'(arg));
    assign unit_end_c = (phase == PH_W'(BURST_UNIT - 1));
    assign n_c        = (arg[3:0] == 4'd0) ? 4'd1 : arg[3:0];

    always_comb begin
      led_c = 1'b0;
      case (mode)
        M_ON:      led_c = 1'b1;
        M_BLINK:   led_c = blink_lvl;
        M_PWM:     led_c = (pwm_cnt < arg);
        M_BREATHE: led_c = (pwm_cnt < duty);
        M_BURST:   led_c = (bst == PULSE_HI) && !armed;
        default:   led_c = 1'b0;
      endcase
    end

    // Channel state: reset beats write, write beats tick.
    always_ff @(posedge clk) begin
      if (rst) begin
        mode      <= '0;
        arg       <= '0;
        duty      <= '0;
        phase     <= '0;
        pulse     <= '0;
        dir_dn    <= 1'b0;
        blink_lvl <= 1'b0;
        armed     <= 1'b1;
        bst       <= GAP;
        led_q     <= 1'b0;
      end else begin
        led_q <= led_c;
        if (sel) begin
          mode      <= wr_mode;
          arg       <= wr_arg;
          duty      <= '0;
          phase     <= '0;
          pulse     <= '0;
          dir_dn    <= 1'b0;
          blink_lvl <= 1'b0;
          armed     <= 1'b1;
          bst       <= GAP;
        end else if (tick_c) begin
          case (mode)
            M_BLINK: begin
              if (step_c) begin
                phase     <= '0;
                blink_lvl <= ~blink_lvl;
              end else begin
                phase <= phase + 1'b1;
              end
            end
            M_BREATHE: begin
              if (step_c) begin
                phase <= '0;
                if (!dir_dn) begin
                  if (duty == DUTY_MAX) dir_dn <= 1'b1;
                  else                  duty   <= duty + 1'b1;
                end else begin
                  if (duty == '0) dir_dn <= 1'b0;
                  else            duty   <= duty - 1'b1;
                end
              end else begin
                phase <= phase + 1'b1;
              end
            end
            M_BURST: begin
              case (bst)
                PULSE_HI: begin
                  if (unit_end_c) begin
                    bst   <= PULSE_LO;
                    phase <= '0;
                  end else begin
                    phase <= phase + 1'b1;
                  end
                end
                PULSE_LO: begin
                  if (unit_end_c) begin
                    phase <= '0;
                    if (({1'b0, pulse} + 5'd1) >= {1'b0, n_c}) begin
                      bst   <= GAP;
                      pulse <= '0;
                    end else begin
                      bst   <= PULSE_HI;
                      pulse <= pulse + 1'b1;
                    end
                  end else begin
                    phase <= phase + 1'b1;
                  end
                end
                default: begin
                  // armed: first tick after a write starts the first pulse
                  if (armed || (phase == PH_W'(BURST_GAP - 1))) begin
                    bst   <= PULSE_HI;
                    phase <= '0;
                    pulse <= '0;
                    armed <= 1'b0;
                  end else begin
                    phase <= phase + 1'b1;
                  end
                end
              endcase
            end
            default: ;
          endcase
        end
      end
    end

    assign led[i] = led_q;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Multi-channel LED pattern generator.
- Each of N_CH outputs is independently programmed to one of six modes: off, on, blink, fixed PWM, breathe, or burst (N pulses then gap).
- A shared prescaler produces a periodic tick, and a shared PWM counter is common to all channels.
- Sits between board-level LEDs and control logic (CPU or debug FSM), replacing per-LED hand-written blinkers.

Parameters:
- CLK_HZ, 25_000_000, input clock frequency in Hz.
- TICK_HZ, 1000, pattern tick rate in Hz; CLK_HZ/TICK_HZ must be an integer of at least 2.
- N_CH, 4, number of LED channels, 1..16.
- PWM_BITS, 8, PWM and duty resolution.
- BURST_UNIT, 50, burst pulse on time and off time, in ticks.
- BURST_GAP, 500, idle time after the last burst pulse, in ticks.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  single-cycle configuration write strobe.
- wr_ch  in  4  target channel index.
- wr_mode  in  3  mode code: 0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 BREATHE, 5 BURST; codes 6 and 7 are treated as OFF.
- wr_arg  in  PWM_BITS  mode argument.
- led  out  N_CH  registered LED outputs, active high.
- tick  out  1  one-clk pulse each tick period, for debug and sync.

Behaviour:
- **Reset.** Synchronous, active-high reset on clk.
  - led=0, tick=0, prescaler=0, pwm_cnt=0.
  - Every channel is set to mode OFF, arg=0, and its phase counter, duty, direction and pulse counter are cleared.
  - Reset asserted mid-pattern takes effect at the next edge and overrides a simultaneous wr_en.
- **Prescaler.**
  - Counts 0..CLK_HZ/TICK_HZ-1 and wraps.
  - tick=1 for exactly the one cycle in which the counter wraps, so the first tick occurs CLK_HZ/TICK_HZ cycles after reset release.
- **PWM counter.** pwm_cnt is a free-running PWM_BITS counter incremented every clk and wrapping at 2^PWM_BITS-1.
- **Configuration write.**
  - When wr_en=1 and wr_ch<N_CH, the target channel's mode and arg are loaded on that edge.
  - The write also clears the channel's phase counter, pulse counter, duty and direction.
  - The new pattern is visible on led from the next cycle.
  - When wr_ch>=N_CH the write is ignored with no effect.
  - Other channels are unaffected by a write.
  - If a write and a tick coincide, the write wins for the target channel and that tick is not counted by it.
- **Output latency.** led is registered; led[i] reflects the state computed from the previous cycle's channel state (1 clk latency).
- **OFF:** led=0.
- **ON:** led=1.
- **BLINK:**
  - led starts at 0 after the write.
  - led toggles each time arg+1 ticks have elapsed, giving a period of 2*(arg+1) ticks.
- **PWM:**
  - led = (pwm_cnt < arg).
  - arg=0 gives constant 0; the maximum arg gives a duty of (2^PWM_BITS-1)/2^PWM_BITS.
- **BREATHE:**
  - led = (pwm_cnt < duty).
  - duty starts at 0, direction up; every arg+1 ticks duty steps by 1.
  - At duty = 2^PWM_BITS-1 the direction flips to down; at 0 it flips to up.
  - Duty holds at the endpoint for one step, with no overshoot or wrap.
- **BURST:**
  - n = arg[3:0], with n=0 treated as 1.
  - The sequence is n repetitions of (BURST_UNIT ticks high, BURST_UNIT ticks low), followed by BURST_GAP ticks low, then repeat.
  - The first high starts at the first tick after the write.
  - The pulse counter is saturating-safe and always returns to 0 at the gap end.
- **Phase counters.** Phase counters are wide enough for max(256, BURST_UNIT, BURST_GAP) ticks and never wrap within a mode.
- **Structure.** Implemented with a per-channel generate loop; BURST uses a 3-state FSM: PULSE_HI, PULSE_LO, GAP.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (tick every 10 clk), PWM_BITS=4, BURST_UNIT=2, BURST_GAP=5, N_CH=4.
1. Reset release with no writes -> led=0000 for 200 clk; tick pulses at cycles 10, 20, 30..., each exactly 1 clk wide.
2. Write ch0 BLINK arg=1; ch1 ON -> led[1]=1 from the next cycle; led[0] toggles every 2 ticks (20 clk), period 40 clk, first rise about 20 clk after the write.
3. Write ch2 PWM arg=4 -> over any 16-clk window led[2] is high for exactly 4 cycles; then write arg=0 -> led[2] stays 0.
4. Write ch3 BURST arg=3 -> 3 pulses, each 20 clk high and 20 clk low, then 50 clk low, repeating every 170 clk; then write arg=0 -> a single pulse per 90-clk frame.
5. Write ch0 BREATHE arg=0 -> duty ramps 0→15 in 15 ticks, then ramps down; the measured high count per 16-clk window tracks duty within ±1 and never exceeds 15.
6. Edge cases:
   - Write with wr_ch=5 -> no channel changes.
   - Write coinciding with tick -> target phase restarts with no extra toggle.
   - Assert rst mid-BURST together with wr_en -> led=0000 and all modes OFF next cycle.
